// File: rtl/pid_pkg.sv
// Shared PID-path types: integrator FSM states, mode encodings and default widths.
package pid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    ACC   = 2'd2,
    CLAMP = 2'd3
  } state_e;

  localparam logic MODE_TRAP = 1'b0;
  localparam logic MODE_RECT = 1'b1;

  localparam int unsigned ADC_WIDTH_DEF = 13;
  localparam int unsigned ACC_WIDTH_DEF = 2 * ADC_WIDTH_DEF;
  localparam int unsigned N_CH_DEF      = 4;
  localparam int unsigned CH_W_DEF      = 2;

endpackage

// File: rtl/integral_acc_mc_if.sv
// Request/result bundle between the error subtractor, the integrator and the PID sum stage.
interface integral_acc_mc_if
  import pid_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned CH_W      = CH_W_DEF
);
  logic                        int_en;
  logic                        int_clr;
  logic [CH_W-1:0]             chan;
  logic                        mode;
  logic signed [ADC_WIDTH-1:0] cur_error;
  logic [ACC_WIDTH-2:0]        int_limit;
  logic                        busy;
  logic                        int_valid;
  logic [CH_W-1:0]             int_chan;
  logic signed [ACC_WIDTH-1:0] int_out;
  logic                        int_sat;
  logic                        req_drop;

  modport master (
    output int_en, int_clr, chan, mode, cur_error, int_limit,
    input  busy, int_valid, int_chan, int_out, int_sat, req_drop
  );

  modport slave (
    input  int_en, int_clr, chan, mode, cur_error, int_limit,
    output busy, int_valid, int_chan, int_out, int_sat, req_drop
  );
endinterface

// File: rtl/integral_acc_mc_int_sat.sv
// Symmetric signed clamp of the widened accumulator sum to [-limit, +limit].
module int_sat #(
  parameter int unsigned ACC_WIDTH = 26
) (
  input  logic signed [ACC_WIDTH:0]   acc_next_i,
  input  logic        [ACC_WIDTH-2:0] limit_i,
  output logic signed [ACC_WIDTH-1:0] res_c_o,
  output logic                        sat_c_o
);
  logic signed [ACC_WIDTH:0] pos_lim;
  logic signed [ACC_WIDTH:0] neg_lim;

  always_comb begin
    pos_lim = $signed({2'b00, limit_i});
    neg_lim = -pos_lim;
    res_c_o = acc_next_i[ACC_WIDTH-1:0];
    sat_c_o = 1'b0;
    if (acc_next_i > pos_lim) begin
      res_c_o = pos_lim[ACC_WIDTH-1:0];
      sat_c_o = 1'b1;
    end else if (acc_next_i < neg_lim) begin
      res_c_o = neg_lim[ACC_WIDTH-1:0];
      sat_c_o = 1'b1;
    end
  end
endmodule

// File: rtl/integral_acc_mc.sv
// Multi-channel trapezoidal/rectangular error integrator with anti-windup clamp,
// one shared datapath time-multiplexed over N_CH channel register files.
module integral_acc_mc
  import pid_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = 2 * ADC_WIDTH,
  parameter int unsigned N_CH      = N_CH_DEF
) (
  input logic              clk,
  input logic              rst,
  integral_acc_mc_if.slave bus_if
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned ESW  = ADC_WIDTH + 1;
  localparam int unsigned AW1  = ACC_WIDTH + 1;

  state_e state_q, state_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic                        mode_q, mode_d;
  logic signed [ADC_WIDTH-1:0] cur_q, cur_d;
  logic signed [ESW-1:0]       esum_q, esum_d;

  logic                        busy_q;
  logic                        valid_q;
  logic [CH_W-1:0]             int_chan_q;
  logic signed [ACC_WIDTH-1:0] int_out_q;
  logic                        sat_q;
  logic                        drop_q;

  logic signed [ACC_WIDTH-1:0] acc_mem_q [N_CH];
  logic signed [ADC_WIDTH-1:0] old_mem_q [N_CH];

  logic                        accept_win;
  logic                        chan_ok;
  logic                        do_int;
  logic                        do_clr;
  logic                        drop_d;
  logic signed [AW1-1:0]       acc_next;
  logic signed [ACC_WIDTH-1:0] clamp_res;
  logic                        clamp_sat;

  // CLAMP only presents the registered result, so it takes new requests like IDLE.
  always_comb begin
    accept_win = (state_q == IDLE) || (state_q == CLAMP);
    chan_ok    = 32'(bus_if.chan) < N_CH;
    do_clr     = accept_win && chan_ok && bus_if.int_clr;
    do_int     = accept_win && chan_ok && bus_if.int_en && !bus_if.int_clr;
    drop_d     = ((bus_if.int_en || bus_if.int_clr) && (!accept_win || !chan_ok)) ||
                 (accept_win && chan_ok && bus_if.int_en && bus_if.int_clr);
    acc_next   = AW1'(acc_mem_q[ch_q]) + AW1'(esum_q);
  end

  int_sat #(.ACC_WIDTH(ACC_WIDTH)) u_int_sat (
    .acc_next_i (acc_next),
    .limit_i    (bus_if.int_limit),
    .res_c_o    (clamp_res),
    .sat_c_o    (clamp_sat)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    esum_d  = esum_q;
    case (state_q)
      IDLE, CLAMP: begin
        state_d = IDLE;
        if (do_int) begin
          ch_d    = bus_if.chan;
          mode_d  = bus_if.mode;
          cur_d   = bus_if.cur_error;
          state_d = SUM;
        end
      end
      SUM: begin
        if (mode_q == MODE_RECT) begin
          esum_d = {cur_q, 1'b0};
        end else begin
          esum_d = ESW'(cur_q) + ESW'(old_mem_q[ch_q]);
        end
        state_d = ACC;
      end
      ACC:     state_d = CLAMP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      mode_q     <= MODE_TRAP;
      cur_q      <= '0;
      esum_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      int_chan_q <= '0;
      int_out_q  <= '0;
      sat_q      <= 1'b0;
      drop_q     <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        acc_mem_q[i] <= '0;
        old_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      esum_q  <= esum_d;
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_q == ACC);
      drop_q  <= drop_d;
      // Result and channel write-back land together so a reset before this edge leaves no trace.
      if (state_q == ACC) begin
        int_out_q       <= clamp_res;
        sat_q           <= clamp_sat;
        int_chan_q      <= ch_q;
        acc_mem_q[ch_q] <= clamp_res;
        old_mem_q[ch_q] <= cur_q;
      end
      if (do_clr) begin
        acc_mem_q[bus_if.chan] <= '0;
        old_mem_q[bus_if.chan] <= '0;
      end
    end
  end

  assign bus_if.busy      = busy_q;
  assign bus_if.int_valid = valid_q;
  assign bus_if.int_chan  = int_chan_q;
  assign bus_if.int_out   = int_out_q;
  assign bus_if.int_sat   = sat_q;
  assign bus_if.req_drop  = drop_q;
endmodule

// File: tb/tb_integral_acc_mc.sv
// Scoreboard bench for integral_acc_mc: expected results queued at request time, popped on int_valid.
module tb_integral_acc_mc;
  import pid_pkg::*;

  localparam longint LIM_MAX = 33554431;

  typedef struct {
    int     ch;
    longint out;
    logic   sat;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb[$];

  integral_acc_mc_if #(.ADC_WIDTH(13), .ACC_WIDTH(26), .CH_W(2)) bus ();

  integral_acc_mc #(.ADC_WIDTH(13), .ACC_WIDTH(26), .N_CH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.int_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("int_out", longint'(bus.int_out), e.out);
        check_eq("int_chan", longint'(bus.int_chan), longint'(e.ch));
        check_eq("int_sat", longint'(bus.int_sat), longint'(e.sat));
      end
    end
  end

  // Issue one integrate in the current cycle; returns in cycle 3 after checking the strobe timing.
  task automatic do_int(input int ch, input logic md, input int cur, input longint lim,
                        input longint exp_out, input logic exp_sat);
    exp_t e;
    bus.int_en    = 1'b1;
    bus.chan      = 2'(ch);
    bus.mode      = md;
    bus.cur_error = 13'(cur);
    bus.int_limit = 25'(lim);
    e.ch  = ch;
    e.out = exp_out;
    e.sat = exp_sat;
    sb.push_back(e);
    step();
    bus.int_en = 1'b0;
    check_eq("busy_c1", longint'(bus.busy), 1);
    step();
    check_eq("valid_c2", longint'(bus.int_valid), 0);
    step();
    check_eq("valid_c3", longint'(bus.int_valid), 1);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.int_en    = 1'b0;
    bus.int_clr   = 1'b0;
    bus.chan      = '0;
    bus.mode      = MODE_TRAP;
    bus.cur_error = '0;
    bus.int_limit = 25'(LIM_MAX);
    step(); step(); step();
    rst = 1'b0;
    check_eq("rst_busy", longint'(bus.busy), 0);
    check_eq("rst_valid", longint'(bus.int_valid), 0);
    check_eq("rst_out", longint'(bus.int_out), 0);
    check_eq("rst_drop", longint'(bus.req_drop), 0);
    step();

    // Trapezoidal ch0, back-to-back at full throughput.
    do_int(0, MODE_TRAP, 100, LIM_MAX, 100, 1'b0);
    do_int(0, MODE_TRAP, 200, LIM_MAX, 400, 1'b0);
    do_int(0, MODE_TRAP, -100, LIM_MAX, 500, 1'b0);
    do_int(0, MODE_TRAP, 300, LIM_MAX, 700, 1'b0);

    // Rectangular ch1, then ch0 state must be unchanged.
    do_int(1, MODE_RECT, 50, LIM_MAX, 100, 1'b0);
    do_int(1, MODE_RECT, -20, LIM_MAX, 60, 1'b0);
    do_int(0, MODE_TRAP, 0, LIM_MAX, 1000, 1'b0);

    // Anti-windup on ch2, then a zero limit.
    do_int(2, MODE_TRAP, 100, 150, 100, 1'b0);
    do_int(2, MODE_TRAP, 100, 150, 150, 1'b1);
    do_int(2, MODE_TRAP, -200, 150, 50, 1'b0);
    do_int(2, MODE_TRAP, 3, 0, 0, 1'b1);
    step();

    // Handshake: second request while busy is dropped; request in cycle 3 is accepted.
    begin
      exp_t e;
      e.ch = 3; e.out = 5; e.sat = 1'b0;
      bus.int_en = 1'b1; bus.chan = 2'd3; bus.mode = MODE_TRAP;
      bus.cur_error = 13'sd5; bus.int_limit = 25'(LIM_MAX);
      sb.push_back(e);
      step();
      bus.cur_error = 13'sd99;
      step();
      bus.int_en = 1'b0;
      check_eq("hs_drop_c2", longint'(bus.req_drop), 1);
      step();
      check_eq("hs_valid_c3", longint'(bus.int_valid), 1);
      do_int(3, MODE_TRAP, 1, LIM_MAX, 11, 1'b0);
    end
    step();

    // Clear and integrate together: clear wins, integrate dropped, no result.
    bus.int_clr = 1'b1; bus.int_en = 1'b1; bus.chan = 2'd0; bus.cur_error = 13'sd77;
    step();
    bus.int_clr = 1'b0; bus.int_en = 1'b0;
    check_eq("clr_drop", longint'(bus.req_drop), 1);
    check_eq("clr_busy", longint'(bus.busy), 0);
    do_int(0, MODE_TRAP, 10, LIM_MAX, 10, 1'b0);

    // Plain clear on ch1, then integrate on it right away.
    bus.int_clr = 1'b1; bus.chan = 2'd1;
    step();
    bus.int_clr = 1'b0;
    check_eq("clr1_drop", longint'(bus.req_drop), 0);
    do_int(1, MODE_RECT, 5, LIM_MAX, 10, 1'b0);
    step();

    // Reset in cycle 2 of a request aborts it.
    bus.int_en = 1'b1; bus.chan = 2'd1; bus.mode = MODE_TRAP; bus.cur_error = 13'sd55;
    step();
    bus.int_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("ab_valid", longint'(bus.int_valid), 0);
    check_eq("ab_busy", longint'(bus.busy), 0);
    check_eq("ab_out", longint'(bus.int_out), 0);
    check_eq("ab_chan", longint'(bus.int_chan), 0);
    check_eq("ab_sat", longint'(bus.int_sat), 0);
    check_eq("ab_drop", longint'(bus.req_drop), 0);
    do_int(1, MODE_TRAP, 7, LIM_MAX, 7, 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check_eq("sb_empty", longint'(sb.size()), 0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
